// File: rtl/mux_scan_sequencer.sv
// Scans a 16:1 mux channel by channel, settling after each select change,
// and assembles the sampled bits into one word handed off with valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        mux_out_i,
  input  logic        ready_i,
  output logic [3:0]  sel_o,
  output logic        busy_o,
  output logic [15:0] data_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  sel_q;
  logic [3:0]  cnt_q;
  logic [15:0] capture_q;
  logic [15:0] data_q;
  logic        valid_q;
  logic        busy_q;
  logic        launch;

  // A new scan may begin from IDLE, or straight out of HOLD on the accepting edge.
  assign launch = start_i && ((state_q == IDLE) || (state_q == HOLD && ready_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= 4'd0;
      cnt_q     <= 4'd0;
      capture_q <= 16'h0000;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (launch) begin
      state_q   <= FIRST_STATE;
      sel_q     <= 4'd0;
      cnt_q     <= 4'd0;
      capture_q <= 16'h0000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        SETTLE: begin
          if (abort_i) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            cnt_q     <= 4'd0;
            capture_q <= 16'h0000;
            busy_q    <= 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          // Abort wins over the capture so a partial word never survives.
          if (abort_i) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            cnt_q     <= 4'd0;
            capture_q <= 16'h0000;
            busy_q    <= 1'b0;
          end else begin
            capture_q[sel_q] <= mux_out_i;
            if (sel_q == 4'd15) begin
              data_q  <= {mux_out_i, capture_q[14:0]};
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= HOLD;
            end else begin
              sel_q   <= sel_q + 4'd1;
              cnt_q   <= 4'd0;
              state_q <= FIRST_STATE;
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
